i2c_master_controller: RTL and testbench

//  Single-master I2C controller. A one-cycle init pulse launches one complete bus transaction:

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_qtick.sv | 36 +++
 rtl/i2c_master_controller.sv | 189 ++++++++++++++++++
 tb/tb_i2c_master_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// i2c_pkg: shared types for the single-master I2C controller.
//   state_t  - transaction FSM states
//   qphase_t - quarter of the current SCL bit period
//   top_byte - index of the highest set bit in a byte-enable mask
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, DATA, DACK, READ, MACK, STOP
  } state_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} qphase_t;

  // Bytes go out highest index first, so the walker always picks the top set bit.
  function automatic logic [1:0] top_byte(input logic [3:0] mask);
    if (mask[3]) return 2'd3;
    if (mask[2]) return 2'd2;
    if (mask[1]) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
`timescale 1ns/1ps
// i2c_qtick: quarter-bit tick generator.
//   clock   in  system clock
//   reset_n in  synchronous active-low reset
//   run     in  count while high, counter cleared while low
//   hold    in  freeze at the end of the quarter (SCL stretching)
//   tick    out one-clock pulse every QDIV clocks unless held
module i2c_qtick #(
  parameter int QDIV = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  input  logic hold,
  output logic tick
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(QDIV - 1));
  assign tick   = run && at_end && !hold;

  always_ff @(posedge clock) begin
    if (!reset_n || !run) begin
      cnt <= '0;
    end else if (!at_end) begin
      cnt <= cnt + CW'(1);
    end else if (!hold) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/i2c_master_controller.sv
`timescale 1ns/1ps
// i2c_master_controller: single-master I2C controller. One init pulse runs
// START, {address, rw}, up to four data bytes (enabled by bytesend, sent
// byte 3 down to byte 0), STOP. Reads shift data in and discard it.
//   clock    in    system clock
//   reset_n  in    synchronous active-low reset
//   init     in    start request, sampled in IDLE only
//   rw       in    R/W bit of the address byte
//   address  in    7-bit slave address
//   data     in    32-bit write payload, byte i = data[8i+7:8i]
//   bytesend in    byte-enable mask
//   i2c_err  out   slave NACK seen during the last transaction
//   i2c_sda  inout open-drain data line (0 or Z)
//   i2c_scl  inout open-drain clock line (0 or Z)
module i2c_master_controller
  import i2c_pkg::*;
#(
  parameter int QDIV = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        init,
  input  logic        rw,
  input  logic [6:0]  address,
  input  logic [31:0] data,
  input  logic [3:0]  bytesend,
  output logic        i2c_err,
  inout  wire         i2c_sda,
  inout  wire         i2c_scl
);

  state_t      state_q, state_d;
  qphase_t     phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  mask_q, mask_d;
  logic        err_q, err_d;
  logic [7:0]  sh_q, sh_d;
  logic [6:0]  addr_q;
  logic        rw_q;
  logic [31:0] data_q;
  logic        sda_low_q, scl_low_q;
  logic        sda_low_n, scl_low_n, sda_upd;
  logic        tick, hold, next_byte;
  logic [1:0]  byte_idx;

  assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;
  assign i2c_scl = scl_low_q ? 1'b0 : 1'bz;
  assign i2c_err = err_q;

  // A slave holding SCL low after we release it stalls the Q2->Q3 advance.
  // Our own release reaches the pin one clock late, so at QDIV = 1 the hold
  // also covers that clock.
  assign hold = (phase_q == Q2) && !i2c_scl;

  i2c_qtick #(.QDIV(QDIV)) u_qtick (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (state_q != IDLE),
    .hold    (hold),
    .tick    (tick)
  );

  assign byte_idx = top_byte(mask_q);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    mask_d    = mask_q;
    err_d     = err_q;
    sh_d      = sh_q;
    next_byte = 1'b0;

    if (state_q == IDLE) begin
      phase_d = Q0;
      if (init) begin
        state_d = START;
        mask_d  = bytesend;
        err_d   = 1'b0;
      end
    end else if (tick) begin
      phase_d = qphase_t'(phase_q + 2'd1);
      if (phase_q == Q3) begin
        case (state_q)
          START: begin
            state_d = ADDR;
            bit_d   = 3'd0;
            sh_d    = {addr_q, rw_q};
          end
          ADDR, DATA: begin
            sh_d = {sh_q[6:0], 1'b0};
            if (bit_q == 3'd7) state_d = (state_q == ADDR) ? AACK : DACK;
            else               bit_d   = bit_q + 3'd1;
          end
          READ: begin
            sh_d = {sh_q[6:0], i2c_sda};
            if (bit_q == 3'd7) state_d = MACK;
            else               bit_d   = bit_q + 3'd1;
          end
          AACK, DACK: begin
            if (i2c_sda) begin
              err_d   = 1'b1;
              state_d = STOP;
            end else begin
              next_byte = 1'b1;
            end
          end
          MACK:    next_byte = 1'b1;
          STOP:    state_d   = IDLE;
          default: state_d   = IDLE;
        endcase
      end
    end

    // Byte-mask walker: consume the highest enabled byte, or finish.
    if (next_byte) begin
      if (mask_q == 4'd0) begin
        state_d = STOP;
      end else begin
        state_d = rw_q ? READ : DATA;
        bit_d   = 3'd0;
        sh_d    = data_q[{byte_idx, 3'b000} +: 8];
        mask_d  = mask_q & ~(4'b0001 << byte_idx);
      end
    end
  end

  // Line drive decode. Bit slots hold SCL low in Q0/Q1; START and STOP use
  // the quarters to order the SDA edge against the high SCL.
  always_comb begin
    scl_low_n = 1'b0;
    sda_low_n = 1'b0;
    case (state_q)
      IDLE: ;
      START: begin
        sda_low_n = phase_q[1];
        scl_low_n = (phase_q == Q3);
      end
      STOP: begin
        scl_low_n = !phase_q[1];
        sda_low_n = (phase_q != Q3);
      end
      ADDR, DATA: begin
        scl_low_n = !phase_q[1];
        sda_low_n = !sh_q[7];
      end
      MACK: begin
        scl_low_n = !phase_q[1];
        sda_low_n = (mask_q != 4'd0);
      end
      default: scl_low_n = !phase_q[1];
    endcase
  end

  // Inside bit slots SDA may only move once SCL is actually low on the pin,
  // which keeps it from racing the falling SCL edge of Q0.
  assign sda_upd = !i2c_scl || (state_q == IDLE) || (state_q == START) ||
                   ((state_q == STOP) && phase_q[1]);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= Q0;
      bit_q     <= 3'd0;
      mask_q    <= 4'd0;
      err_q     <= 1'b0;
      sda_low_q <= 1'b0;
      scl_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
      scl_low_q <= scl_low_n;
      if (sda_upd) sda_low_q <= sda_low_n;
    end
  end

  always_ff @(posedge clock) begin
    sh_q <= sh_d;
    if (state_q == IDLE && init) begin
      addr_q <= address;
      rw_q   <= rw;
      data_q <= data;
    end
  end

endmodule

// File: tb/tb_i2c_master_controller.sv
`timescale 1ns/1ps
// Bench for i2c_master_controller: pull-ups on SDA/SCL, QDIV = 2, 20 ns
// clock, a behavioural slave that logs bytes, ACKs, returns read data and
// can stretch SCL.
module tb_i2c_master_controller;

  logic        clock, reset_n, init, rw;
  logic [6:0]  address;
  logic [31:0] data;
  logic [3:0]  bytesend;
  logic        i2c_err;
  wire         sda_w, scl_w;

  pullup (sda_w);
  pullup (scl_w);

  i2c_master_controller #(.QDIV(2)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .init     (init),
    .rw       (rw),
    .address  (address),
    .data     (data),
    .bytesend (bytesend),
    .i2c_err  (i2c_err),
    .i2c_sda  (sda_w),
    .i2c_scl  (scl_w)
  );

  int checks = 0;
  int errors = 0;
  int cyc_now = 0;

  // Slave controls written by the main sequence only.
  logic       slave_present = 1'b0;
  logic       stretch_en    = 1'b0;
  logic [7:0] rd_b [0:3];

  // Slave state, written by the slave process only.
  logic       s_sda_low = 1'b0, s_scl_low = 1'b0;
  logic       pscl = 1'b1, psda = 1'b1;
  logic       in_frame = 1'b0, is_read = 1'b0, tx_done = 1'b0, stretch_done = 1'b0;
  logic [7:0] sh = 8'h00, tx = 8'h00;
  logic [7:0] log_b [0:7];
  logic       mack_b [0:7];
  int         pos = 0, bidx = 0, nlog = 0, nmack = 0, stretch_left = 0;
  int         start_cnt = 0, stop_cnt = 0;

  assign sda_w = s_sda_low ? 1'b0 : 1'bz;
  assign scl_w = s_scl_low ? 1'b0 : 1'bz;

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc_now++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  // Behavioural slave, evaluated away from the DUT clock edge.
  initial forever begin
    @(negedge clock);
    if (scl_w && pscl && psda && !sda_w) begin
      start_cnt++;
      in_frame = 1'b1; pos = 0; bidx = 0; nlog = 0; nmack = 0;
      is_read = 1'b0; tx_done = 1'b0; stretch_done = 1'b0; s_sda_low = 1'b0;
    end else if (scl_w && pscl && !psda && sda_w) begin
      stop_cnt++;
      in_frame = 1'b0; s_sda_low = 1'b0;
    end else if (in_frame && !pscl && scl_w) begin
      if (pos < 8) begin
        sh = {sh[6:0], sda_w};
      end else if (is_read && bidx > 0) begin
        if (nmack < 8) mack_b[nmack] = sda_w;
        nmack++;
        if (sda_w) tx_done = 1'b1;
      end
      pos++;
    end else if (in_frame && pscl && !scl_w) begin
      s_sda_low = 1'b0;
      if (pos == 8) begin
        if (nlog < 8) log_b[nlog] = sh;
        nlog++;
        if (bidx == 0) is_read = sh[0];
        s_sda_low = slave_present && (bidx == 0 || !is_read);
      end else if (pos == 9) begin
        pos = 0;
        bidx++;
        if (is_read && !tx_done) tx = rd_b[(bidx - 1) % 4];
      end
      if (pos < 8 && slave_present && is_read && bidx > 0 && !tx_done) begin
        s_sda_low = !tx[7];
        tx = {tx[6:0], 1'b0};
      end
      if (stretch_en && !stretch_done && bidx == 0 && pos == 3) begin
        stretch_left = 40;
        stretch_done = 1'b1;
      end
    end
    s_scl_low = (stretch_left > 0);
    if (stretch_left > 0) stretch_left--;
    pscl = scl_w;
    psda = sda_w;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [6:0] a, input logic r, input logic [31:0] d,
                        input logic [3:0] m, output int t0);
    @(negedge clock);
    address = a; rw = r; data = d; bytesend = m; init = 1'b1;
    t0 = cyc_now;
    @(negedge clock);
    init = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int stops0, input int t0, output int dur);
    while (stop_cnt == stops0 && (cyc_now - t0) < 400) @(negedge clock);
    dur = cyc_now - t0;
    check(tag, (stop_cnt != stops0 && dur < 300), 1);
    repeat (10) @(negedge clock);
  endtask

  int t0, dur, dur2, s_stop, s_start, n;

  initial begin
    reset_n = 1'b0; init = 1'b0; rw = 1'b0; address = 7'h00; data = 32'h0; bytesend = 4'h0;
    rd_b[0] = 8'h55; rd_b[1] = 8'hAA; rd_b[2] = 8'h00; rd_b[3] = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_sda", sda_w, 1'b1);
    check("rst_scl", scl_w, 1'b1);
    check("rst_err", i2c_err, 1'b0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // 1: no slave, address NACK
    slave_present = 1'b0;
    s_stop = stop_cnt;
    launch(7'h1F, 1'b0, 32'd32, 4'b1000, t0);
    wait_done("t1_done", s_stop, t0, dur);
    check("t1_nlog", nlog, 1);
    check("t1_addr", log_b[0], 8'h3E);
    check("t1_err", i2c_err, 1'b1);
    check("t1_stops", stop_cnt - s_stop, 1);
    repeat (20) @(negedge clock);
    check("t1_err_hold", i2c_err, 1'b1);

    // 2: ACKing slave, one byte
    slave_present = 1'b1;
    s_stop = stop_cnt; s_start = start_cnt;
    launch(7'h1F, 1'b0, 32'd32, 4'b1000, t0);
    check("t2_err_clr", i2c_err, 1'b0);
    wait_done("t2_done", s_stop, t0, dur2);
    check("t2_nlog", nlog, 2);
    check("t2_b0", log_b[0], 8'h3E);
    check("t2_b1", log_b[1], 8'h00);
    check("t2_err", i2c_err, 1'b0);
    check("t2_starts", start_cnt - s_start, 1);
    check("t2_stops", stop_cnt - s_stop, 1);

    // 3: sparse mask, bytes 2 then 0
    s_stop = stop_cnt;
    launch(7'h1F, 1'b0, 32'hA1B2C3D4, 4'b0101, t0);
    wait_done("t3_done", s_stop, t0, dur);
    check("t3_nlog", nlog, 3);
    check("t3_b0", log_b[0], 8'h3E);
    check("t3_b1", log_b[1], 8'hB2);
    check("t3_b2", log_b[2], 8'hD4);

    // 4: read two bytes
    s_stop = stop_cnt;
    launch(7'h1F, 1'b1, 32'h0, 4'b0011, t0);
    wait_done("t4_done", s_stop, t0, dur);
    check("t4_nlog", nlog, 3);
    check("t4_addr", log_b[0], 8'h3F);
    check("t4_r0", log_b[1], 8'h55);
    check("t4_r1", log_b[2], 8'hAA);
    check("t4_nmack", nmack, 2);
    check("t4_mack0", mack_b[0], 1'b0);
    check("t4_mack1", mack_b[1], 1'b1);
    check("t4_err", i2c_err, 1'b0);

    // 5: SCL stretch in address bit 3, plus an ignored init mid-transfer
    stretch_en = 1'b1;
    s_stop = stop_cnt; s_start = start_cnt;
    launch(7'h1F, 1'b0, 32'd32, 4'b1000, t0);
    repeat (20) @(negedge clock);
    address = 7'h55; rw = 1'b1; bytesend = 4'b1111; init = 1'b1;
    @(negedge clock);
    init = 1'b0;
    wait_done("t5_done", s_stop, t0, dur);
    stretch_en = 1'b0;
    check("t5_nlog", nlog, 2);
    check("t5_b0", log_b[0], 8'h3E);
    check("t5_b1", log_b[1], 8'h00);
    check("t5_starts", start_cnt - s_start, 1);
    check("t5_stretched", dur > dur2 + 30, 1);
    check("t5_err", i2c_err, 1'b0);

    // 6: reset in the middle of a data byte
    s_stop = stop_cnt;
    launch(7'h1F, 1'b0, 32'd32, 4'b1000, t0);
    n = 0;
    while (!(bidx == 1 && pos == 3 && !scl_w) && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("t6_reach", n < 400, 1);
    check("t6_sda_pre", sda_w, 1'b0);
    reset_n = 1'b0;
    @(negedge clock);
    check("t6_sda_rel", sda_w, 1'b1);
    check("t6_scl_rel", scl_w, 1'b1);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    check("t6_no_stop", stop_cnt - s_stop, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
